// File: rtl/demux_bit_sequencer.sv
// Feeds the 1-to-8 bit demultiplexer: takes an 8-bit word over valid/ready and
// plays it out one bit per lane, stepping the select 0..7.
module demux_bit_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  logic       abort_i,
    output logic       dm_in_o,
    output logic [2:0] dm_sel_o,
    output logic       dm_valid_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q;
    logic [2:0]    lane_q;
    logic [HW-1:0] hold_q;
    logic [7:0]    word_q;
    logic          dm_in_q;
    logic          ready_q;
    logic          done_q;

    logic [7:0]    word_d;
    logic          accept;
    logic          hold_end;
    logic          lane_end;

    // word_d is pre-ordered so lane k always takes bit k, whatever LSB_FIRST says
    always_comb begin
        word_d = s_data_i;
        if (!LSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                word_d[i] = s_data_i[7-i];
            end
        end
        accept   = s_valid_i && s_ready_o;
        hold_end = (hold_q == HOLD_LAST);
        lane_end = (lane_q == 3'd7);
    end

    assign s_ready_o  = ready_q && !abort_i;
    assign dm_in_o    = dm_in_q;
    assign dm_sel_o   = lane_q;
    assign dm_valid_o = (state_q == SEND);
    assign busy_o     = (state_q == SEND);
    assign done_o     = done_q;

    // Accept is only possible in IDLE or in the final hold cycle of lane 7,
    // so a SEND-state accept always completes a word and reloads without a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lane_q  <= 3'd0;
            hold_q  <= '0;
            word_q  <= 8'd0;
            dm_in_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                lane_q  <= 3'd0;
                hold_q  <= '0;
                word_q  <= 8'd0;
                dm_in_q <= 1'b0;
                ready_q <= 1'b1;
            end else if (accept) begin
                done_q  <= (state_q == SEND);
                state_q <= SEND;
                lane_q  <= 3'd0;
                hold_q  <= '0;
                dm_in_q <= word_d[0];
                word_q  <= {1'b0, word_d[7:1]};
                ready_q <= 1'b0;
            end else if (state_q == SEND) begin
                if (!hold_end) begin
                    hold_q  <= hold_q + 1'b1;
                    ready_q <= lane_end && ((hold_q + 1'b1) == HOLD_LAST);
                end else if (!lane_end) begin
                    hold_q  <= '0;
                    lane_q  <= lane_q + 3'd1;
                    dm_in_q <= word_q[0];
                    word_q  <= {1'b0, word_q[7:1]};
                    ready_q <= (lane_q == 3'd6) && (HOLD_LAST == '0);
                end else begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    lane_q  <= 3'd0;
                    hold_q  <= '0;
                    dm_in_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// Bench for demux_bit_sequencer: two instances (LSB-first/hold 1 and MSB-first/hold 3)
// checked every cycle against a queue-of-beats model plus hand-computed expectations.
`timescale 1ns/1ps
module tb_demux_bit_sequencer;

    localparam int HOLD0 = 1;
    localparam int HOLD1 = 3;

    typedef struct {
        logic [2:0] sel;
        logic       b;
        logic       last;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [7:0] sData   [2];
    logic       sValid  [2];
    logic       abortIn [2];
    logic       sReady  [2];
    logic       dmIn    [2];
    logic [2:0] dmSel   [2];
    logic       dmValid [2];
    logic       busy    [2];
    logic       done    [2];

    beat_t      mq [2][$];
    logic       doneExp [2];
    logic       acc [2];

    int         checks;
    int         errors;
    int         cycleNo;

    int         validCount [2];
    int         onesCount  [2];
    int         doneCount  [2];
    int         firstValid [2];
    int         lastValid  [2];
    int         firstSel   [2];
    int         sel7Cycle  [2];
    int         firstDone  [2];
    int         lastDone   [2];
    logic [7:0] laneByte   [2];

    demux_bit_sequencer #(.HOLD_CYCLES(HOLD0), .LSB_FIRST(1'b1)) u0 (
        .clk_i(clk), .rst_i(rst), .s_data_i(sData[0]), .s_valid_i(sValid[0]),
        .s_ready_o(sReady[0]), .abort_i(abortIn[0]), .dm_in_o(dmIn[0]),
        .dm_sel_o(dmSel[0]), .dm_valid_o(dmValid[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    demux_bit_sequencer #(.HOLD_CYCLES(HOLD1), .LSB_FIRST(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst), .s_data_i(sData[1]), .s_valid_i(sValid[1]),
        .s_ready_o(sReady[1]), .abort_i(abortIn[1]), .dm_in_o(dmIn[1]),
        .dm_sel_o(dmSel[1]), .dm_valid_o(dmValid[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cycleNo);
        end
    endfunction

    function automatic int holdOf(int d);
        return (d == 0) ? HOLD0 : HOLD1;
    endfunction

    // Expected beats: each lane k repeated HOLD times; lane k carries bit k (LSB-first) or bit 7-k
    function automatic void pushWord(int d, logic [7:0] data);
        beat_t bt;
        for (int lane = 0; lane < 8; lane++) begin
            for (int h = 0; h < holdOf(d); h++) begin
                bt.sel  = 3'(lane);
                bt.b    = (d == 0) ? data[lane] : data[7-lane];
                bt.last = (lane == 7) && (h == holdOf(d) - 1);
                mq[d].push_back(bt);
            end
        end
    endfunction

    task automatic checkOutput();
        for (int d = 0; d < 2; d++) begin
            logic live;
            live = (mq[d].size() > 0);
            check("dm_valid", d, 32'(dmValid[d]), 32'(live));
            check("busy", d, 32'(busy[d]), 32'(live));
            check("dm_sel", d, 32'(dmSel[d]), live ? 32'(mq[d][0].sel) : 32'd0);
            check("dm_in", d, 32'(dmIn[d]), live ? 32'(mq[d][0].b) : 32'd0);
            check("done", d, 32'(done[d]), 32'(doneExp[d]));
            check("s_ready", d, 32'(sReady[d]), 32'((mq[d].size() <= 1) && !abortIn[d]));
        end
    endtask

    task automatic clearObs(int d);
        validCount[d] = 0; onesCount[d] = 0; doneCount[d] = 0;
        firstValid[d] = -1; lastValid[d] = -1; firstSel[d] = -1;
        sel7Cycle[d] = -1; firstDone[d] = -1; lastDone[d] = -1;
        laneByte[d] = 8'h00;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge
    task automatic applyStimulus();
        logic [7:0] dataPre [2];
        logic       abortPre [2];
        for (int d = 0; d < 2; d++) begin
            acc[d]      = sValid[d] && !abortIn[d] && (mq[d].size() <= 1) && !rst;
            dataPre[d]  = sData[d];
            abortPre[d] = abortIn[d];
        end
        @(posedge clk);
        cycleNo++;
        for (int d = 0; d < 2; d++) begin
            logic poppedLast;
            poppedLast = 1'b0;
            if (rst) begin
                mq[d].delete();
                doneExp[d] = 1'b0;
            end else begin
                if (mq[d].size() > 0) poppedLast = mq[d].pop_front().last;
                if (abortPre[d]) begin
                    mq[d].delete();
                    doneExp[d] = 1'b0;
                end else begin
                    doneExp[d] = poppedLast;
                    if (acc[d]) pushWord(d, dataPre[d]);
                end
            end
        end
        @(negedge clk);
        checkOutput();
        for (int d = 0; d < 2; d++) begin
            if (dmValid[d]) begin
                validCount[d]++;
                onesCount[d] += int'(dmIn[d]);
                laneByte[d][dmSel[d]] = dmIn[d];
                if (firstValid[d] < 0) begin
                    firstValid[d] = cycleNo;
                    firstSel[d]   = int'(dmSel[d]);
                end
                lastValid[d] = cycleNo;
                if (dmSel[d] == 3'd7) sel7Cycle[d] = cycleNo;
            end
            if (done[d]) begin
                doneCount[d]++;
                if (firstDone[d] < 0) firstDone[d] = cycleNo;
                lastDone[d] = cycleNo;
            end
        end
    endtask

    task automatic send(int d, logic [7:0] data);
        bit taken;
        taken     = 1'b0;
        sValid[d] = 1'b1;
        sData[d]  = data;
        for (int n = 0; n < 100 && !taken; n++) begin
            applyStimulus();
            taken = acc[d];
        end
        check("send_accepted", d, 32'(taken), 32'd1);
        sValid[d] = 1'b0;
    endtask

    task automatic runCycles(int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        bit found;
        checks = 0; errors = 0; cycleNo = 0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sData[d] = 8'h00; sValid[d] = 1'b0; abortIn[d] = 1'b0; doneExp[d] = 1'b0;
            clearObs(d);
        end
        runCycles(3);

        // Reset release and idle
        rst = 1'b0;
        clearObs(0); clearObs(1);
        runCycles(5);
        for (int d = 0; d < 2; d++) begin
            check("idle_done_count", d, 32'(doneCount[d]), 32'd0);
            check("idle_ready", d, 32'(sReady[d]), 32'd1);
            check("idle_valid_count", d, 32'(validCount[d]), 32'd0);
        end

        // LSB-first, hold 1: 8'hA5 -> lanes a..h = 1,0,1,0,0,1,0,1
        clearObs(0);
        send(0, 8'hA5);
        runCycles(9);
        check("a5_lanes", 0, 32'(laneByte[0]), 32'h0000_00A5);
        check("a5_valid_count", 0, 32'(validCount[0]), 32'd8);
        check("a5_first_sel", 0, 32'(firstSel[0]), 32'd0);
        check("a5_done_count", 0, 32'(doneCount[0]), 32'd1);
        check("a5_done_after_sel7", 0, 32'(firstDone[0] - sel7Cycle[0]), 32'd1);

        // MSB-first, hold 3: 8'h81 -> 24 valid cycles, lanes 0 and 7 high for 3 cycles each
        clearObs(1);
        send(1, 8'h81);
        runCycles(26);
        check("81_lanes", 1, 32'(laneByte[1]), 32'h0000_0081);
        check("81_valid_count", 1, 32'(validCount[1]), 32'd24);
        check("81_ones_count", 1, 32'(onesCount[1]), 32'd6);
        check("81_done_count", 1, 32'(doneCount[1]), 32'd1);

        // MSB-first hold 3 asymmetric word pins the lane ordering: 8'h0F -> lanes 4..7 high
        clearObs(1);
        send(1, 8'h0F);
        runCycles(26);
        check("0f_lanes", 1, 32'(laneByte[1]), 32'h0000_00F0);
        check("0f_ones_count", 1, 32'(onesCount[1]), 32'd12);

        // Back-to-back FF then 00 with valid held
        clearObs(0);
        send(0, 8'hFF);
        send(0, 8'h00);
        runCycles(10);
        check("b2b_valid_count", 0, 32'(validCount[0]), 32'd16);
        check("b2b_contiguous", 0, 32'(lastValid[0] - firstValid[0] + 1), 32'd16);
        check("b2b_first_done", 0, 32'(firstDone[0] - firstValid[0] + 1), 32'd9);
        check("b2b_last_done", 0, 32'(lastDone[0] - lastValid[0]), 32'd1);
        check("b2b_done_count", 0, 32'(doneCount[0]), 32'd2);
        check("b2b_lanes", 0, 32'(laneByte[0]), 32'h0000_0000);

        // Abort at sel=4 of 8'h3C, with a competing offer of 8'h01 in the abort cycle
        clearObs(0);
        send(0, 8'h3C);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (dmValid[0] && dmSel[0] == 3'd4) found = 1'b1;
            else applyStimulus();
        end
        check("abort_reached_sel4", 0, 32'(found), 32'd1);
        abortIn[0] = 1'b1;
        sValid[0]  = 1'b1;
        sData[0]   = 8'h01;
        #1;
        check("abort_ready_forced", 0, 32'(sReady[0]), 32'd0);
        applyStimulus();
        abortIn[0] = 1'b0;
        sValid[0]  = 1'b0;
        check("abort_valid", 0, 32'(dmValid[0]), 32'd0);
        check("abort_busy", 0, 32'(busy[0]), 32'd0);
        runCycles(3);
        check("abort_no_done", 0, 32'(doneCount[0]), 32'd0);
        clearObs(0);
        send(0, 8'h01);
        runCycles(9);
        check("post_abort_first_sel", 0, 32'(firstSel[0]), 32'd0);
        check("post_abort_lanes", 0, 32'(laneByte[0]), 32'h0000_0001);
        check("post_abort_done", 0, 32'(doneCount[0]), 32'd1);

        // Asynchronous reset between edges, mid-word on both instances
        send(0, 8'hC3);
        send(1, 8'hF0);
        runCycles(2);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("arst_valid", d, 32'(dmValid[d]), 32'd0);
            check("arst_busy", d, 32'(busy[d]), 32'd0);
            check("arst_sel", d, 32'(dmSel[d]), 32'd0);
            check("arst_in", d, 32'(dmIn[d]), 32'd0);
            check("arst_ready", d, 32'(sReady[d]), 32'd1);
            check("arst_done", d, 32'(done[d]), 32'd0);
            mq[d].delete();
            doneExp[d] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        checkOutput();
        clearObs(0);
        send(0, 8'h55);
        runCycles(9);
        check("after_rst_lanes", 0, 32'(laneByte[0]), 32'h0000_0055);
        check("after_rst_valid_count", 0, 32'(validCount[0]), 32'd8);
        check("after_rst_done", 0, 32'(doneCount[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
